// File: rtl/prog_uart_loader.sv
// rtl/prog_uart_loader.sv - 8N1 UART receiver that packs bytes into words and loads instruction memory
module prog_uart_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_WIDTH   = 8,
  parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  en_i,
  input  logic                  rx_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  done_o,
  output logic                  frame_err_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]         BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]         HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WORD} state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic [BW-1:0]         baud_cnt;
  logic [2:0]            bit_cnt;
  logic [1:0]            byte_idx;
  logic [7:0]            shift;
  logic [31:0]           word;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           word_next;

  // Current word with the freshly received byte dropped into its lane
  always_comb begin
    word_next = word;
    word_next[{byte_idx, 3'b000} +: 8] = shift;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      shift       <= '0;
      word        <= '0;
      addr        <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
      word_cnt_o  <= '0;
    end else begin
      rx_meta  <= rx_i;
      rx_s     <= rx_meta;
      mem_we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (en_i && !done_o && !rx_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              frame_err_o <= 1'b1;
              state       <= IDLE;
            end else begin
              word <= word_next;
              if (byte_idx == 2'd3) begin
                // Write is launched here so the strobe is visible during WORD
                state <= WORD;
                if (word_next == END_WORD) begin
                  done_o <= 1'b1;
                end else begin
                  mem_we_o    <= 1'b1;
                  mem_addr_o  <= addr;
                  mem_wdata_o <= word_next;
                  word_cnt_o  <= word_cnt_o + 1'b1;
                  if (addr == ADDR_MAX) done_o <= 1'b1;
                  else                  addr   <= addr + 1'b1;
                end
              end else begin
                byte_idx <= byte_idx + 1'b1;
                state    <= IDLE;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        WORD: begin
          byte_idx <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_uart_loader.sv
// tb/tb_prog_uart_loader.sv - randomized bench for prog_uart_loader with a byte-stream reference model
module tb_prog_uart_loader;
  localparam int          CPB   = 4;
  localparam int          AW    = 4;
  localparam logic [31:0] END_W = 32'h00000FFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          rx  = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          done;
  logic          frame_err;
  logic [AW:0]   word_cnt;

  always #5 clk = ~clk;

  prog_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .END_WORD(END_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en_i       (en),
    .rx_i       (rx),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .done_o     (done),
    .frame_err_o(frame_err),
    .word_cnt_o (word_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a stream of accepted bytes grouped four at a time
  logic [7:0]  m_bytes[$];
  int          m_addr;
  int          m_cnt;
  bit          m_done;
  bit          m_ferr;
  logic [31:0] m_last_addr;
  logic [31:0] m_last_data;
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  function automatic void model_reset();
    m_bytes.delete();
    exp_addr.delete();
    exp_data.delete();
    m_addr = 0; m_cnt = 0; m_done = 0; m_ferr = 0;
    m_last_addr = 0; m_last_data = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] w;
    if (!en || m_done) return;
    if (!stop_ok) begin
      m_ferr = 1;
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() < 4) return;
    w = 32'(m_bytes[0]) + (32'(m_bytes[1]) << 8) + (32'(m_bytes[2]) << 16) + (32'(m_bytes[3]) << 24);
    m_bytes.delete();
    if (w == END_W) begin
      m_done = 1;
      return;
    end
    exp_addr.push_back(m_addr);
    exp_data.push_back(w);
    m_last_addr = m_addr;
    m_last_data = w;
    m_cnt++;
    if (m_addr == (1 << AW) - 1) m_done = 1;
    else m_addr++;
  endfunction

  always @(negedge clk) begin
    if (mem_we) begin
      check("wr_expected", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) begin
        check("wr_addr", mem_addr, exp_addr.pop_front());
        check("wr_data", mem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    rx = 1'b0; hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; hold(CPB);
    end
    model_byte(b, stop_ok);
    rx = stop_ok; hold(CPB);
    rx = 1'b1; hold(6 + $urandom_range(0, 4));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic partial_byte(input logic [7:0] b);
    rx = 1'b0; hold(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i]; hold(CPB);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == END_W) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic check_state(input string tag);
    hold(20);
    check({tag, "_pending"}, exp_addr.size(), 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_done"}, done, m_done);
    check({tag, "_ferr"}, frame_err, m_ferr);
    check({tag, "_cnt"}, word_cnt, m_cnt);
    check({tag, "_addr"}, mem_addr, m_last_addr);
    check({tag, "_wdata"}, mem_wdata, m_last_data);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx = 1'b1;
    hold(2);
    model_reset();
    rst = 1'b0;
    hold(4);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; en = 1'b1; rx = 1'b1;
    hold(3);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_cnt", word_cnt, 0);
    rst = 1'b0;
    hold(4);

    rx = 1'b0; hold(1); rx = 1'b1;
    check_state("glitch");

    send_word(32'h00000013);
    send_word(32'h00100093);
    send_word(END_W);
    check_state("prog");
    send_word(rand_word());
    check_state("after_done");

    do_reset();
    send_byte(8'h55, 1'b0);
    send_word(32'hDDCCBBAA);
    check_state("frame_err");

    send_byte(8'h11);
    partial_byte(8'h5A);
    rst = 1'b1; rx = 1'b1;
    hold(1);
    check("midrst_we", mem_we, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_wdata", mem_wdata, 0);
    check("midrst_done", done, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_cnt", word_cnt, 0);
    model_reset();
    rst = 1'b0;
    hold(4);
    send_word(rand_word());
    check_state("post_rst");

    do_reset();
    en = 1'b0;
    send_word(rand_word());
    check_state("en_low");
    en = 1'b1;
    send_word(rand_word());
    send_byte($urandom_range(0, 255));
    send_byte($urandom_range(0, 255));
    partial_byte(8'hC3);
    en = 1'b0; rx = 1'b1;
    hold(8);
    en = 1'b1;
    hold(4);
    send_byte($urandom_range(0, 255));
    send_byte($urandom_range(0, 255));
    check_state("en_abort");

    do_reset();
    for (int i = 0; i < 17; i++) send_word(rand_word());
    check_state("fill");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/prog_uart_loader.md
Name: prog_uart_loader

Overview:
- UART receiver plus program loader on the user-project side of the serial boot path.
- Receives 8N1 bytes on a GPIO-mapped RX pin and packs them little-endian into 32-bit words.
- Writes each word sequentially into instruction memory, then signals done so the core can leave reset.
- Sits between the mprj_io RX pad and the instruction-memory write port; the bench-side program transmitter drives its input.

Parameters:
- CLKS_PER_BIT, 434, wb_clk_i cycles per UART bit (integer ≥ 4).
- ADDR_WIDTH, 8, word-address width of instruction memory.
- END_WORD, 32'h00000FFF, terminator word; ends loading and is not written.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  loader enable; low holds the receiver in IDLE.
- rx_i  in  1  UART serial input; idles high.
- mem_we_o  out  1  one-cycle instruction-memory write strobe.
- mem_addr_o  out  ADDR_WIDTH  word address of the current write.
- mem_wdata_o  out  32  write data.
- done_o  out  1  sticky; load finished (END_WORD seen or memory full).
- frame_err_o  out  1  sticky; a stop bit was sampled low.
- word_cnt_o  out  ADDR_WIDTH+1  number of words written so far.

Behaviour:
- Reset (wb_rst_i=1 at a clock edge): all outputs are 0; FSM goes to IDLE; bit, byte and baud counters, address and the shift register are cleared; the 2-flop synchronizer is set to 1.
- Input path: rx_i passes through a 2-flop synchronizer (rx_s). All timing below is relative to rx_s.
- Receiver FSM: IDLE, START, DATA, STOP, WORD.
  - IDLE: when en_i=1, done_o=0 and rx_s=0, go to START and clear the baud counter. Otherwise stay.
  - START: at count CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - 0: clear the baud counter and go to DATA.
    - 1: glitch; return to IDLE with no side effects.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first. After 8 bits go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: byte is valid. Place it in word lane byte_idx (byte 0 → bits[7:0]) and increment byte_idx.
    - If byte_idx was 3, go to WORD; otherwise go to IDLE.
    - 0: set frame_err_o, discard the byte, leave byte_idx unchanged, go to IDLE. The receiver waits for rx_s=0 again.
  - WORD: lasts one cycle and clears byte_idx.
    - If the word equals END_WORD: set done_o, no write.
    - Else: mem_we_o=1 for this single cycle, with mem_addr_o = current address and mem_wdata_o = assembled word. Then increment the address and word_cnt_o.
    - If this write was to address 2^ADDR_WIDTH-1: set done_o (memory full; the address does not wrap).
    - Next state is IDLE.
- Latency: mem_we_o is asserted 1 cycle after the 4th byte's stop-bit sample cycle.
- mem_addr_o and mem_wdata_o hold their last values between writes.
- done_o=1: the FSM stays in IDLE and further rx traffic is ignored. Only reset clears done_o.
- en_i falling mid-byte: the FSM aborts to IDLE on the next edge. The partial byte is dropped; byte_idx and the address are retained, so the next frame continues the same word.
- en_i has no effect on outputs already asserted.
- frame_err_o does not stop loading.
- Reset mid-frame takes priority over everything. No write is issued in the reset cycle.

Test Plan:
- CLKS_PER_BIT=4, ADDR_WIDTH=4. Send bytes 13 00 00 00, 93 00 10 00, FF 0F 00 00 → mem_we_o pulses exactly twice: addr 0 = 32'h00000013, addr 1 = 32'h00100093. done_o=1 after the third word, word_cnt_o=2, no third write.
- 1-cycle low glitch on rx_i while IDLE → no state advance, no write, frame_err_o=0.
- Byte 0x55 sent with the stop bit held low → frame_err_o=1, byte discarded. Then send AA BB CC DD → one write of 32'hDDCCBBAA at addr 0.
- Send 16 non-terminator words → writes at addr 0..15. done_o=1 after addr 15. A 17th word produces no write and addr does not wrap.
- Assert wb_rst_i during the DATA bits of byte 2 → all outputs 0 next cycle. A fresh 4-byte word afterwards is written at addr 0 with correct data.
- en_i=0 while sending 4 bytes → no writes. Set en_i=1, resend → normal write at addr 0.
